// File: rtl/fma16_wb.sv
// fma16 writeback queue: buffers {result, flags, rd} from the fma16 datapath
// ahead of the register-file write port, accumulates sticky exception flags
// at acceptance time and counts accepted operations.
module fma16_wb #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic [3:0]  in_flags,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic [4:0]  out_rd,
  output logic [3:0]  fflags,
  input  logic        fflags_clr,
  output logic [15:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] full_cnt = (AW+1)'(DEPTH);

  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // in_ready looks only at occupancy, so a full queue stays closed even when
  // the consumer pops this cycle; the freed slot opens next cycle.
  assign in_ready  = (count < full_cnt) & ~reset;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is read straight from storage; nothing bypasses from the inputs.
  assign {out_result, out_flags, out_rd} = mem[rd_ptr];

  // Entry storage: written only on an accepted push, no reset needed since
  // out_valid hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_result, in_flags, in_rd};
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky flags: clear wins over accumulation, but a push in the clear cycle
  // still records its own flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      fflags <= 4'b0000;
    end else if (fflags_clr) begin
      fflags <= push ? in_flags : 4'b0000;
    end else if (push) begin
      fflags <= fflags | in_flags;
    end
  end

  // Accepted-operation counter, free-running wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= 16'h0000;
    end else if (push) begin
      op_count <= op_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fma16_wb.sv
// Self-checking bench for fma16_wb: a queue-based reference model compared on
// every falling edge, plus directed sequences with literal expectations.
module tb_fma16_wb;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic [4:0]  out_rd;
  logic [3:0]  fflags;
  logic        fflags_clr;
  logic [15:0] op_count;

  fma16_wb #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_rd(out_rd),
    .fflags(fflags), .fflags_clr(fflags_clr), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Reference model state
  logic [24:0] q[$];
  logic [3:0]  m_fflags = 4'b0;
  logic [15:0] m_opcnt = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: acceptance decided on occupancy before this edge
  always @(posedge clk) begin
    bit do_push, do_pop;
    if (reset) begin
      q.delete();
      m_fflags = 4'b0;
      m_opcnt  = 16'h0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({in_result, in_flags, in_rd});
        m_opcnt = m_opcnt + 16'h1;
      end
      if (fflags_clr) m_fflags = do_push ? in_flags : 4'b0;
      else if (do_push) m_fflags = m_fflags | in_flags;
    end
  end

  // Continuous compare against the model
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < DEPTH) && !reset});
      chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0)
        chk("head", {7'b0, out_result, out_flags, out_rd}, {7'b0, q[0]});
      chk("fflags", {28'b0, fflags}, {28'b0, m_fflags});
      chk("op_count", {16'b0, op_count}, {16'b0, m_opcnt});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; fflags_clr = 1'b0;
    cyc();
    chk("in_ready_in_reset", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] f, input logic [4:0] d);
    in_valid = v; in_result = r; in_flags = f; in_rd = d;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_flags = '0; in_rd = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    cyc();
    started = 1'b1;
    cyc();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("post_reset_fflags", {28'b0, fflags}, 32'd0);
    chk("post_reset_op_count", {16'b0, op_count}, 32'd0);

    // Basic flow
    out_ready = 1'b1;
    drive(1'b1, 16'h3C00, 4'b0001, 5'd5);
    cyc();
    in_valid = 1'b0;
    chk("basic_valid", {31'b0, out_valid}, 32'd1);
    chk("basic_result", {16'b0, out_result}, 32'h3C00);
    chk("basic_rd", {27'b0, out_rd}, 32'd5);
    chk("basic_fflags", {28'b0, fflags}, 32'd1);
    chk("basic_op_count", {16'b0, op_count}, 32'd1);
    cyc();
    chk("basic_drained", {31'b0, out_valid}, 32'd0);

    // Fill and backpressure
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'b0000, 5'd1);
    cyc();
    drive(1'b1, 16'h0002, 4'b0000, 5'd2);
    cyc();
    in_valid = 1'b0;
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_head", {16'b0, out_result}, 32'h0001);
    drive(1'b1, 16'h0003, 4'b1111, 5'd3);
    cyc();
    in_valid = 1'b0;
    chk("dropped_op_count", {16'b0, op_count}, 32'd2);
    chk("dropped_fflags", {28'b0, fflags}, 32'd0);
    chk("held_head", {16'b0, out_result}, 32'h0001);
    out_ready = 1'b1;
    #1;
    chk("full_with_out_ready", {31'b0, in_ready}, 32'd0);
    cyc();
    chk("drain_second", {16'b0, out_result}, 32'h0002);
    cyc();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Simultaneous push/pop at count 1, pointers wrap several times
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 16'h0100 + 16'(i), 4'b0000, 5'(i));
      cyc();
      chk("stream_head", {16'b0, out_result}, 32'h0100 + i);
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    cyc();

    // Sticky flags
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h1111, 4'b1000, 5'd7);
    cyc();
    drive(1'b1, 16'h2222, 4'b0100, 5'd8);
    cyc();
    in_valid = 1'b0;
    chk("sticky_or", {28'b0, fflags}, 32'hC);
    fflags_clr = 1'b1;
    cyc();
    fflags_clr = 1'b0;
    chk("sticky_clr", {28'b0, fflags}, 32'h0);
    fflags_clr = 1'b1;
    drive(1'b1, 16'h3333, 4'b0010, 5'd9);
    cyc();
    fflags_clr = 1'b0; in_valid = 1'b0;
    chk("sticky_clr_push", {28'b0, fflags}, 32'h2);
    cyc();

    // Reset with two entries queued
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 4'b1010, 5'd10);
    cyc();
    drive(1'b1, 16'hBBBB, 4'b0101, 5'd11);
    cyc();
    reset = 1'b1; fflags_clr = 1'b1; out_ready = 1'b1;
    cyc();
    reset = 1'b0; fflags_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_fflags", {28'b0, fflags}, 32'd0);
    chk("rst_mid_op_count", {16'b0, op_count}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 5'($urandom));
      out_ready  = $urandom_range(0, 2) != 0;
      fflags_clr = $urandom_range(0, 15) == 0;
      reset      = $urandom_range(0, 199) == 0;
      cyc();
    end
    reset = 1'b0; fflags_clr = 1'b0; in_valid = 1'b0;

    // op_count wrap after 65536 accepted pushes
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 16'h5A5A, 4'b0000, 5'd1);
    for (int i = 0; i < 65536; i++) cyc();
    in_valid = 1'b0;
    chk("op_count_wrap", {16'b0, op_count}, 32'h0000);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
